// File: rtl/amba_ahb_master.sv
// amba_ahb_master: pipelined AHB-Lite master turning a valid/ready command stream into bus beats.
// Define AHB_MASTER_BURST_EN to issue runs of four cmd_burst beats as INCR4 with BUSY on gaps.
module amba_ahb_master (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [2:0]  cmd_size,
  input  logic        cmd_burst,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        hsel,
  output logic [31:0] haddr,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [2:0]  hburst,
  output logic [3:0]  hprot,
  output logic [1:0]  htrans,
  output logic [31:0] hwdata,
  input  logic [31:0] hrdata,
  input  logic        hready,
  input  logic        hresp
);
  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_ERR1, S_ERR2} state_t;
  state_t r_state, w_state_n;
  logic r_ready_en, r_ap_v, r_ap_seq, r_ap_inc, r_dp_v, r_dp_write, r_hwrite, r_rsp_valid, r_rsp_err;
  logic [31:0] r_haddr, r_ap_wdata, r_hwdata, r_rsp_rdata;
  logic [2:0] r_hsize;
  logic w_good, w_err1, w_err_cyc, w_ap_adv, w_dp_fin, w_acc, w_ap_n, w_dp_n, w_show;
  logic w_busy, w_seq_n, w_inc_n;
  assign w_good    = cmd_size < 3'd3;
  assign w_err1    = r_state == S_ACTIVE && r_dp_v && hresp && !hready;
  assign w_err_cyc = w_err1 || r_state == S_ERR1;
  assign w_ap_adv  = r_ap_v && hready && r_state != S_ERR1;
  assign w_dp_fin  = r_dp_v && hready;
  // an illegal-size beat is only taken with the pipe empty so its response stays in order
  assign cmd_ready = r_ready_en && !w_err_cyc && (!r_ap_v || w_ap_adv) && (w_good || (!r_ap_v && !r_dp_v));
  assign w_acc     = cmd_valid && cmd_ready;
  assign w_ap_n    = (w_acc && w_good) || (r_ap_v && !w_ap_adv);
  assign w_dp_n    = w_ap_adv || (r_dp_v && !w_dp_fin);
  assign w_show    = r_ap_v && r_state != S_ERR1;
`ifdef AHB_MASTER_BURST_EN
  logic [1:0] r_bcnt;
  logic r_single;
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_bcnt   <= 2'd0;
      r_single <= 1'b0;
    end else begin
      if (w_acc && w_good && cmd_burst) r_bcnt <= r_bcnt + 2'd1;
      if (w_acc && w_good && cmd_burst && r_bcnt == 2'd3) r_single <= 1'b0;
      else if (w_err1 && r_bcnt != 2'd0) r_single <= 1'b1;
    end
  end
  assign w_seq_n = cmd_burst && !r_single && r_bcnt != 2'd0;
  assign w_inc_n = cmd_burst && !r_single;
  assign w_busy  = r_bcnt != 2'd0 && !r_single && !r_ap_v && r_state != S_ERR1;
`else
  logic w_unused_burst;
  assign w_unused_burst = cmd_burst;
  assign w_seq_n = 1'b0;
  assign w_inc_n = 1'b0;
  assign w_busy  = 1'b0;
`endif
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state     <= S_IDLE;
      r_ready_en  <= 1'b0;
      r_ap_v      <= 1'b0;
      r_ap_seq    <= 1'b0;
      r_ap_inc    <= 1'b0;
      r_haddr     <= 32'd0;
      r_hwrite    <= 1'b0;
      r_hsize     <= 3'd0;
      r_ap_wdata  <= 32'd0;
      r_dp_v      <= 1'b0;
      r_dp_write  <= 1'b0;
      r_hwdata    <= 32'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'd0;
    end else begin
      r_state    <= w_state_n;
      r_ready_en <= 1'b1;
      if (w_acc && w_good) begin
        r_ap_v     <= 1'b1;
        r_haddr    <= cmd_addr;
        r_hwrite   <= cmd_write;
        r_hsize    <= cmd_size;
        r_ap_wdata <= cmd_wdata;
        r_ap_seq   <= w_seq_n;
        r_ap_inc   <= w_inc_n;
      end else if (w_ap_adv) begin
        r_ap_v <= 1'b0;
      end else if (w_err1) begin
        r_ap_seq <= 1'b0;
        r_ap_inc <= 1'b0;
      end
      if (w_ap_adv) begin
        r_dp_v     <= 1'b1;
        r_dp_write <= r_hwrite;
        if (r_hwrite) r_hwdata <= r_ap_wdata;
      end else if (w_dp_fin) begin
        r_dp_v <= 1'b0;
      end
      r_rsp_valid <= w_dp_fin || (w_acc && !w_good);
      r_rsp_err   <= w_dp_fin ? (hresp || r_state == S_ERR1) : (w_acc && !w_good);
      r_rsp_rdata <= (w_dp_fin && !r_dp_write) ? hrdata : 32'd0;
    end
  end
  // the held beat is masked to IDLE during the second error cycle
  always_comb begin
    w_state_n = r_state == S_ERR1 ? (hready ? S_ERR2 : S_ERR1) :
                w_err1 ? S_ERR1 : (w_ap_n || w_dp_n) ? S_ACTIVE : S_IDLE;
    htrans    = w_show ? (r_ap_seq ? 2'b11 : 2'b10) : w_busy ? 2'b01 : 2'b00;
    hburst    = (w_show && r_ap_inc) || w_busy ? 3'b011 : 3'b000;
    haddr     = w_busy ? r_haddr + (32'd1 << r_hsize) : r_haddr;
  end
  assign hsel      = |htrans;
  assign hwrite    = r_hwrite;
  assign hsize     = r_hsize;
  assign hprot     = 4'b0011;
  assign hwdata    = r_hwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;
endmodule

// File: tb/tb_amba_ahb_master.sv
// tb_amba_ahb_master: directed bench driving the slave side by hand, one task per scenario.
module tb_amba_ahb_master;
  logic hclk, hresetn, cmd_valid, cmd_ready, cmd_write, cmd_burst, rsp_valid, rsp_err;
  logic hsel, hwrite, hready, hresp;
  logic [31:0] cmd_addr, cmd_wdata, rsp_rdata, haddr, hwdata, hrdata;
  logic [2:0] cmd_size, hsize, hburst;
  logic [3:0] hprot;
  logic [1:0] htrans;
  int errs = 0;
  int chks = 0;

  amba_ahb_master dut (
    .hclk(hclk), .hresetn(hresetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_size(cmd_size),
    .cmd_burst(cmd_burst), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .hsel(hsel), .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
    .htrans(htrans), .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task cyc();
    @(posedge hclk);
    #1;
  endtask

  task smp();
    @(negedge hclk);
  endtask

  task cmd(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] s, input logic b);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_size  = s;
    cmd_burst = b;
  endtask

  task test_reset();
    smp();
    chks++; if (htrans !== 2'b00) begin errs++; $display("FAIL rst_htrans got=%0h exp=0", htrans); end
    chks++; if (hsel !== 1'b0) begin errs++; $display("FAIL rst_hsel got=%0b exp=0", hsel); end
    chks++; if (haddr !== 32'd0) begin errs++; $display("FAIL rst_haddr got=%0h exp=0", haddr); end
    chks++; if (hprot !== 4'b0011) begin errs++; $display("FAIL rst_hprot got=%0h exp=3", hprot); end
    chks++; if (cmd_ready !== 1'b0) begin errs++; $display("FAIL rst_ready got=%0b exp=0", cmd_ready); end
    chks++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL rst_rsp got=%0b exp=0", rsp_valid); end
    cyc();
    hresetn = 1'b1;
    smp();
    chks++; if (cmd_ready !== 1'b0) begin errs++; $display("FAIL rel_ready_pre got=%0b exp=0", cmd_ready); end
    cyc();
    smp();
    chks++; if (cmd_ready !== 1'b1) begin errs++; $display("FAIL rel_ready got=%0b exp=1", cmd_ready); end
    cyc();
  endtask

  task test_write_read();
    cmd(1'b1, 32'h10, 32'hDEADBEEF, 3'd2, 1'b0);
    smp();
    chks++; if (cmd_ready !== 1'b1) begin errs++; $display("FAIL wr_ready got=%0b exp=1", cmd_ready); end
    cyc();
    cmd(1'b0, 32'h10, 32'h0, 3'd2, 1'b0);
    smp();
    chks++; if (htrans !== 2'b10) begin errs++; $display("FAIL wr_htrans got=%0h exp=2", htrans); end
    chks++; if (haddr !== 32'h10 || hwrite !== 1'b1 || hsel !== 1'b1) begin errs++; $display("FAIL wr_addr got=%0h/%0b/%0b exp=10/1/1", haddr, hwrite, hsel); end
    chks++; if (hburst !== 3'b000 || hsize !== 3'd2) begin errs++; $display("FAIL wr_ctl got=%0h/%0h exp=0/2", hburst, hsize); end
    cyc();
    cmd_valid = 1'b0;
    smp();
    chks++; if (hwdata !== 32'hDEADBEEF) begin errs++; $display("FAIL wr_hwdata got=%0h exp=deadbeef", hwdata); end
    chks++; if (htrans !== 2'b10 || hwrite !== 1'b0) begin errs++; $display("FAIL rd_addr got=%0h/%0b exp=2/0", htrans, hwrite); end
    cyc();
    hrdata = 32'hDEADBEEF;
    smp();
    chks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'd0) begin errs++; $display("FAIL wr_rsp got=%0b/%0b/%0h exp=1/0/0", rsp_valid, rsp_err, rsp_rdata); end
    chks++; if (htrans !== 2'b00 || hsel !== 1'b0) begin errs++; $display("FAIL idle_htrans got=%0h/%0b exp=0/0", htrans, hsel); end
    cyc();
    hrdata = 32'd0;
    smp();
    chks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'hDEADBEEF) begin errs++; $display("FAIL rd_rsp got=%0b/%0b/%0h exp=1/0/deadbeef", rsp_valid, rsp_err, rsp_rdata); end
    chks++; if (haddr !== 32'h10) begin errs++; $display("FAIL idle_haddr got=%0h exp=10", haddr); end
    cyc();
    smp();
    chks++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL rsp_once got=%0b exp=0", rsp_valid); end
    cyc();
  endtask

  task test_wait_states();
    cmd(1'b0, 32'h0, 32'h0, 3'd2, 1'b0);
    cyc();
    cmd(1'b0, 32'h4, 32'h0, 3'd2, 1'b0);
    smp();
    chks++; if (haddr !== 32'h0 || htrans !== 2'b10) begin errs++; $display("FAIL ws_a0 got=%0h/%0h exp=0/2", haddr, htrans); end
    cyc();
    cmd_valid = 1'b0;
    hready = 1'b0;
    smp();
    chks++; if (haddr !== 32'h4 || htrans !== 2'b10 || cmd_ready !== 1'b0) begin errs++; $display("FAIL ws_w1 got=%0h/%0h/%0b exp=4/2/0", haddr, htrans, cmd_ready); end
    cyc();
    smp();
    chks++; if (haddr !== 32'h4 || htrans !== 2'b10 || rsp_valid !== 1'b0) begin errs++; $display("FAIL ws_w2 got=%0h/%0h/%0b exp=4/2/0", haddr, htrans, rsp_valid); end
    cyc();
    hready = 1'b1;
    hrdata = 32'h11111111;
    smp();
    chks++; if (haddr !== 32'h4) begin errs++; $display("FAIL ws_hold got=%0h exp=4", haddr); end
    cyc();
    hrdata = 32'h22222222;
    smp();
    chks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h11111111) begin errs++; $display("FAIL ws_rsp0 got=%0b/%0h exp=1/11111111", rsp_valid, rsp_rdata); end
    cyc();
    hrdata = 32'd0;
    smp();
    chks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h22222222) begin errs++; $display("FAIL ws_rsp1 got=%0b/%0h exp=1/22222222", rsp_valid, rsp_rdata); end
    cyc();
    smp();
    chks++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL ws_done got=%0b exp=0", rsp_valid); end
    cyc();
  endtask

  task test_error();
    cmd(1'b1, 32'h20, 32'hA5A5A5A5, 3'd2, 1'b0);
    cyc();
    cmd(1'b0, 32'h24, 32'h0, 3'd2, 1'b0);
    cyc();
    cmd_valid = 1'b0;
    hresp = 1'b1;
    hready = 1'b0;
    smp();
    chks++; if (htrans !== 2'b10 || haddr !== 32'h24 || cmd_ready !== 1'b0) begin errs++; $display("FAIL er_e1 got=%0h/%0h/%0b exp=2/24/0", htrans, haddr, cmd_ready); end
    chks++; if (hwdata !== 32'hA5A5A5A5) begin errs++; $display("FAIL er_hwdata got=%0h exp=a5a5a5a5", hwdata); end
    cyc();
    hready = 1'b1;
    smp();
    chks++; if (htrans !== 2'b00 || hsel !== 1'b0 || cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin errs++; $display("FAIL er_e2 got=%0h/%0b/%0b/%0b exp=0/0/0/0", htrans, hsel, cmd_ready, rsp_valid); end
    cyc();
    hresp = 1'b0;
    hrdata = 32'h33;
    smp();
    chks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin errs++; $display("FAIL er_rsp got=%0b/%0b exp=1/1", rsp_valid, rsp_err); end
    chks++; if (htrans !== 2'b10 || haddr !== 32'h24 || hwrite !== 1'b0 || hburst !== 3'b000) begin errs++; $display("FAIL er_reissue got=%0h/%0h/%0b/%0h exp=2/24/0/0", htrans, haddr, hwrite, hburst); end
    cyc();
    smp();
    chks++; if (htrans !== 2'b00 || rsp_valid !== 1'b0) begin errs++; $display("FAIL er_gap got=%0h/%0b exp=0/0", htrans, rsp_valid); end
    cyc();
    hrdata = 32'd0;
    smp();
    chks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h33) begin errs++; $display("FAIL er_rd got=%0b/%0b/%0h exp=1/0/33", rsp_valid, rsp_err, rsp_rdata); end
    cyc();
  endtask

  task test_single_err();
    cmd(1'b1, 32'h30, 32'h1234, 3'd1, 1'b0);
    cyc();
    cmd_valid = 1'b0;
    smp();
    chks++; if (hsize !== 3'd1 || htrans !== 2'b10) begin errs++; $display("FAIL se_addr got=%0h/%0h exp=1/2", hsize, htrans); end
    cyc();
    hresp = 1'b1;
    cyc();
    hresp = 1'b0;
    smp();
    chks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || htrans !== 2'b00) begin errs++; $display("FAIL se_rsp got=%0b/%0b/%0h exp=1/1/0", rsp_valid, rsp_err, htrans); end
    cyc();
  endtask

  task test_bad_size();
    cmd(1'b0, 32'h80, 32'h0, 3'd3, 1'b0);
    smp();
    chks++; if (cmd_ready !== 1'b1) begin errs++; $display("FAIL bs_ready got=%0b exp=1", cmd_ready); end
    cyc();
    cmd_valid = 1'b0;
    cmd_size = 3'd2;
    smp();
    chks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || htrans !== 2'b00) begin errs++; $display("FAIL bs_rsp got=%0b/%0b/%0h exp=1/1/0", rsp_valid, rsp_err, htrans); end
    chks++; if (haddr !== 32'h30) begin errs++; $display("FAIL bs_haddr got=%0h exp=30", haddr); end
    cyc();
    smp();
    chks++; if (rsp_valid !== 1'b0 || htrans !== 2'b00) begin errs++; $display("FAIL bs_after got=%0b/%0h exp=0/0", rsp_valid, htrans); end
    cyc();
  endtask

`ifdef AHB_MASTER_BURST_EN
  task test_burst();
    cmd(1'b1, 32'h40, 32'h0, 3'd2, 1'b1);
    cyc();
    cmd(1'b1, 32'h44, 32'h1, 3'd2, 1'b1);
    smp();
    chks++; if (htrans !== 2'b10 || haddr !== 32'h40 || hburst !== 3'b011) begin errs++; $display("FAIL bu_b1 got=%0h/%0h/%0h exp=2/40/3", htrans, haddr, hburst); end
    cyc();
    cmd_valid = 1'b0;
    smp();
    chks++; if (htrans !== 2'b11 || haddr !== 32'h44 || hburst !== 3'b011) begin errs++; $display("FAIL bu_b2 got=%0h/%0h/%0h exp=3/44/3", htrans, haddr, hburst); end
    cyc();
    cmd(1'b1, 32'h48, 32'h2, 3'd2, 1'b1);
    smp();
    chks++; if (htrans !== 2'b01 || haddr !== 32'h48 || hburst !== 3'b011) begin errs++; $display("FAIL bu_busy got=%0h/%0h/%0h exp=1/48/3", htrans, haddr, hburst); end
    cyc();
    cmd(1'b1, 32'h4C, 32'h3, 3'd2, 1'b1);
    smp();
    chks++; if (htrans !== 2'b11 || haddr !== 32'h48) begin errs++; $display("FAIL bu_b3 got=%0h/%0h exp=3/48", htrans, haddr); end
    cyc();
    cmd_valid = 1'b0;
    cmd_burst = 1'b0;
    smp();
    chks++; if (htrans !== 2'b11 || haddr !== 32'h4C || hburst !== 3'b011) begin errs++; $display("FAIL bu_b4 got=%0h/%0h/%0h exp=3/4c/3", htrans, haddr, hburst); end
    cyc();
    smp();
    chks++; if (htrans !== 2'b00 || hburst !== 3'b000) begin errs++; $display("FAIL bu_end got=%0h/%0h exp=0/0", htrans, hburst); end
    cyc();
    cyc();
    cyc();
  endtask
`else
  task test_burst();
    cmd(1'b1, 32'h60, 32'h0, 3'd2, 1'b1);
    cyc();
    cmd(1'b1, 32'h64, 32'h1, 3'd2, 1'b1);
    smp();
    chks++; if (htrans !== 2'b10 || hburst !== 3'b000) begin errs++; $display("FAIL nb_b1 got=%0h/%0h exp=2/0", htrans, hburst); end
    cyc();
    cmd_valid = 1'b0;
    cmd_burst = 1'b0;
    smp();
    chks++; if (htrans !== 2'b10 || haddr !== 32'h64 || hburst !== 3'b000) begin errs++; $display("FAIL nb_b2 got=%0h/%0h/%0h exp=2/64/0", htrans, haddr, hburst); end
    cyc();
    smp();
    chks++; if (htrans !== 2'b00 || rsp_valid !== 1'b1) begin errs++; $display("FAIL nb_idle got=%0h/%0b exp=0/1", htrans, rsp_valid); end
    cyc();
    cyc();
  endtask
`endif

  task test_reset_mid();
    cmd(1'b1, 32'h50, 32'h55AA55AA, 3'd2, 1'b0);
    cyc();
    cmd_valid = 1'b0;
    smp();
    chks++; if (htrans !== 2'b10) begin errs++; $display("FAIL rm_addr got=%0h exp=2", htrans); end
    cyc();
    hready = 1'b0;
    smp();
    chks++; if (hwdata !== 32'h55AA55AA) begin errs++; $display("FAIL rm_hwdata got=%0h exp=55aa55aa", hwdata); end
    #1 hresetn = 1'b0;
    #1;
    chks++; if (htrans !== 2'b00 || hsel !== 1'b0 || haddr !== 32'd0 || hwdata !== 32'd0) begin errs++; $display("FAIL rm_bus got=%0h/%0b/%0h/%0h exp=0/0/0/0", htrans, hsel, haddr, hwdata); end
    chks++; if (hwrite !== 1'b0 || hsize !== 3'd0 || hburst !== 3'd0 || hprot !== 4'b0011) begin errs++; $display("FAIL rm_ctl got=%0b/%0h/%0h/%0h exp=0/0/0/3", hwrite, hsize, hburst, hprot); end
    chks++; if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin errs++; $display("FAIL rm_rsp got=%0b/%0b/%0h/%0b exp=0/0/0/0", cmd_ready, rsp_valid, rsp_rdata, rsp_err); end
    cyc();
    hready = 1'b1;
    cyc();
    hresetn = 1'b1;
    smp();
    chks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin errs++; $display("FAIL rm_rel got=%0b/%0b exp=0/0", rsp_valid, cmd_ready); end
    cyc();
    smp();
    chks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || htrans !== 2'b00) begin errs++; $display("FAIL rm_after got=%0b/%0b/%0h exp=0/1/0", rsp_valid, cmd_ready, htrans); end
    cyc();
  endtask

  initial begin
    hresetn = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr = 32'd0;
    cmd_wdata = 32'd0;
    cmd_size = 3'd2;
    cmd_burst = 1'b0;
    hrdata = 32'd0;
    hready = 1'b1;
    hresp = 1'b0;
    test_reset();
    test_write_read();
    test_wait_states();
    test_error();
    test_single_err();
    test_bad_size();
    test_burst();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule

// File: doc/amba_ahb_master.md
AMBA_AHB_MASTER -- requirements
Module: amba_ahb_master

Interface
REQ-001 Parameters: none. Data/address width fixed at 32 bits. HPROT is fixed at 4'b0011 (data, privileged).
REQ-002 hclk  in  1  single clock; all state changes on its rising edge.
REQ-003 hresetn  in  1  asynchronous active-low reset.
REQ-004 cmd_valid  in  1  command beat offered; cmd_ready  out  1  beat accepted when both high at a clock edge.
REQ-005 cmd_write  in  1  (1 write / 0 read); cmd_addr  in  32; cmd_wdata  in  32; cmd_size  in  3  (HSIZE encoding, 0-2 legal); cmd_burst  in  1  beat belongs to an INCR4 burst.
REQ-006 rsp_valid  out  1  one-cycle completion pulse; rsp_rdata  out  32  read data; rsp_err  out  1  slave returned ERROR.
REQ-007 hsel, haddr[31:0], hwrite, hsize[2:0], hburst[2:0], hprot[3:0], htrans[1:0], hwdata[31:0]  out  AHB-Lite master signals to the slave.
REQ-008 hrdata[31:0], hready, hresp  in  AHB-Lite slave response signals.

Function
REQ-009 Pipelined AHB-Lite: address phase of beat N+1 SHALL overlap data phase of beat N; at most one address phase and one data phase outstanding.
REQ-010 cmd_ready SHALL be high when no address phase is pending or the pending address phase completes this cycle (hready=1, no error); low during both ERROR cycles.
REQ-011 Accepted beat SHALL drive haddr/hwrite/hsize/hburst on the following cycle with hsel=1; hwdata SHALL carry that beat's cmd_wdata from the cycle after its address phase completes until its data phase completes.
REQ-012 No accepted beat pending: htrans=IDLE (2'b00), hsel=0, hburst=SINGLE; haddr, hwrite and hsize hold their last values.
REQ-013 Address/control SHALL hold stable while hready=0.
REQ-014 rsp_valid SHALL pulse exactly once per accepted beat, in order, in the cycle after its data phase completes; rsp_rdata = hrdata sampled at completion for reads, 0 for writes.
REQ-015 States: IDLE, ACTIVE (address phase pending or data phase outstanding), ERR1, ERR2.
REQ-016 hresp=1 with hready=0 in a data phase: ACTIVE->ERR1; the pipelined address phase, if any, SHALL be replaced by htrans=IDLE in ERR2 and held internally.
REQ-017 ERR2 (hresp=1, hready=1): respond rsp_err=1 for the failing beat; the held beat SHALL be reissued as NONSEQ/SINGLE; next state ACTIVE if a beat is held, else IDLE.
REQ-018 hresp=1 with hready=1 and no preceding wait cycle SHALL be treated as an ERROR completion (rsp_err=1), without cancellation.
REQ-019 Unsupported cmd_size (>2) SHALL be reported with rsp_valid=1, rsp_err=1 one cycle after acceptance, with no bus transfer.

Reset
REQ-020 While hresetn=0: htrans=IDLE, hsel=0, haddr=0, hwdata=0, hwrite=0, hsize=0, hburst=0, hprot=4'b0011, cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, state IDLE, burst counter 0.
REQ-021 Reset mid-transfer SHALL discard all pending beats with no rsp_valid; cmd_ready=1 from the first edge after release.

Configuration
REQ-022 Macro AHB_MASTER_BURST_EN.
REQ-023 Defined: four consecutive cmd_burst=1 beats SHALL issue as INCR4 (hburst=3'b011): first beat NONSEQ, beats 2-4 SEQ; 2-bit beat counter wraps after beat 4. A gap cycle inside the burst SHALL drive htrans=BUSY (2'b01) with the next address. After an ERROR, the remaining beats SHALL issue as NONSEQ/SINGLE.
REQ-024 Undefined: cmd_burst is ignored; every beat is NONSEQ with hburst=SINGLE; BUSY is never driven.

Verification
REQ-025 Write 0x10 data 0xDEADBEEF size 2, then read 0x10 with hready=1 -> htrans NONSEQ, HWDATA 0xDEADBEEF one cycle after address, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-026 Back-to-back reads 0x0/0x4 with 2 hready=0 wait cycles on the first -> address 0x4 held stable, two in-order rsp_valid pulses.
REQ-027 ERROR on write to 0x20 with a read of 0x24 pipelined -> htrans=IDLE in ERR2, rsp_err=1 for 0x20, 0x24 reissued NONSEQ, rsp_err=0.
REQ-028 With AHB_MASTER_BURST_EN: 4 burst writes 0x40-0x4C, cmd_valid gap before beat 3 -> NONSEQ,SEQ,BUSY,SEQ,SEQ; hburst=3'b011.
REQ-029 hresetn low during a pending write -> all outputs at REQ-020 values, no rsp_valid.
REQ-030 cmd_size=3 -> rsp_err=1 next cycle, htrans stays IDLE.
